// File: rtl/fusion_psum_accumulator.sv
// -----------------------------------------------------------------------------
// fusion_psum_accumulator
//
// Purpose:
//   Accumulates the fusion unit's 8-bit partial sums into a wide signed result.
//   Each beat is sign- or zero-extended, shifted left by a per-beat amount and
//   added to the running sum. The running sum saturates at the signed ACC_W
//   range. A finished sum is presented on acc_out with a valid/ready handshake.
//   Splitting a wide multiply over several narrow beats, or reducing a dot
//   product, both map onto this single structure.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   psum_in    partial sum beat from the fusion unit
//   s_psum     1: psum_in is two's complement; 0: psum_in is unsigned
//   shift_amt  left shift applied to the extended beat
//   in_first   beat opens a new accumulation
//   in_last    beat closes the accumulation
//   in_valid   beat present
//   in_ready   beat can be accepted (combinational)
//   acc_out    finished signed sum
//   out_valid  acc_out holds a finished sum
//   out_ready  consumer takes acc_out
//   sat        finished sum was clamped (qualified by out_valid)
//   overrun    sticky: too many beats without in_last; cleared only by rst
//   beat_cnt   beats accepted in the current accumulation
// -----------------------------------------------------------------------------
module fusion_psum_accumulator #(
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 24,
    parameter int SHIFT_W   = 4,
    parameter int MAX_BEATS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic               s_psum,
    input  logic [SHIFT_W-1:0] shift_amt,
    input  logic               in_first,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sat,
    output logic               overrun,
    output logic [6:0]         beat_cnt
);

    // One guard bit above the accumulator width lets overflow be detected.
    localparam int SUM_W = ACC_W + 1;
    localparam logic [6:0] MAX_CNT = 7'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Extend a beat to the working sum width.
    function automatic logic [SUM_W-1:0] ext_psum(
        input logic [PSUM_W-1:0] p,
        input logic              is_signed
    );
        ext_psum = {{(SUM_W - PSUM_W){is_signed & p[PSUM_W-1]}}, p};
    endfunction

    // Clamp a guard-bit sum to the signed ACC_W range.
    // Returns {clamp_flag, clamped_value}. The two top bits disagree exactly
    // when the value no longer fits in ACC_W signed bits.
    function automatic logic [ACC_W:0] sat_clamp(input logic [SUM_W-1:0] v);
        if (!v[SUM_W-1] && v[SUM_W-2]) begin
            sat_clamp = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end else if (v[SUM_W-1] && !v[SUM_W-2]) begin
            sat_clamp = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sat_clamp = {1'b0, v[ACC_W-1:0]};
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ACC_W-1:0]   acc_r;
    logic               sat_acc_r;
    logic [ACC_W-1:0]   acc_out_r;
    logic               out_valid_r;
    logic               sat_r;
    logic               overrun_r;
    logic [6:0]         beat_cnt_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               start_s;
    logic [SUM_W-1:0]   term_s;
    logic [SUM_W-1:0]   base_s;
    logic [SUM_W-1:0]   sum_s;
    logic               clamp_now_s;
    logic [ACC_W-1:0]   clamped_s;
    logic               sat_nxt_s;

    assign in_ready_s = (state_r != HOLD) | out_ready;
    assign in_ready   = in_ready_s;
    assign acc_out    = acc_out_r;
    assign out_valid  = out_valid_r;
    assign sat        = sat_r;
    assign overrun    = overrun_r;
    assign beat_cnt   = beat_cnt_r;

    // Datapath: extend, shift, add and clamp the current beat.
    always_comb begin
        accept_s = in_valid & in_ready_s;
        // Any beat outside ACCUM opens a fresh sum even without in_first.
        start_s  = in_first | (state_r != ACCUM);
        term_s   = ext_psum(psum_in, s_psum) << shift_amt;
        if (start_s) begin
            base_s = {SUM_W{1'b0}};
        end else begin
            base_s = {acc_r[ACC_W-1], acc_r};
        end
        sum_s                    = base_s + term_s;
        {clamp_now_s, clamped_s} = sat_clamp(sum_s);
        if (start_s) begin
            sat_nxt_s = clamp_now_s;
        end else begin
            sat_nxt_s = sat_acc_r | clamp_now_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    state_nxt_s = in_last ? HOLD : ACCUM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            HOLD: begin
                if (accept_s) begin
                    state_nxt_s = in_last ? HOLD : ACCUM;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Running sum, its clamp history, beat counter and overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r      <= {ACC_W{1'b0}};
            sat_acc_r  <= 1'b0;
            beat_cnt_r <= 7'd0;
            overrun_r  <= 1'b0;
        end else if (accept_s) begin
            acc_r     <= clamped_s;
            sat_acc_r <= sat_nxt_s;
            if (start_s) begin
                beat_cnt_r <= 7'd1;
            end else if (beat_cnt_r == MAX_CNT) begin
                // Counter pins at the limit; the sum itself keeps going.
                if (!in_last) begin
                    overrun_r <= 1'b1;
                end
            end else begin
                beat_cnt_r <= beat_cnt_r + 7'd1;
            end
        end
    end

    // Output register: capture on the closing beat, drop valid on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out_r   <= {ACC_W{1'b0}};
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s && in_last) begin
            acc_out_r   <= clamped_s;
            sat_r       <= sat_nxt_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fusion_psum_accumulator.sv
module tb_fusion_psum_accumulator;

    logic        clk;
    logic        rst;
    logic [7:0]  psum_in;
    logic        s_psum;
    logic [3:0]  shift_amt;
    logic        in_first;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        sat;
    logic        overrun;
    logic [6:0]  beat_cnt;

    int tests = 0;
    int fails = 0;

    fusion_psum_accumulator #(
        .PSUM_W(8), .ACC_W(24), .SHIFT_W(4), .MAX_BEATS(64)
    ) dut (
        .clk(clk), .rst(rst), .psum_in(psum_in), .s_psum(s_psum),
        .shift_amt(shift_amt), .in_first(in_first), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .sat(sat),
        .overrun(overrun), .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, confirm it is acceptable, clock it in, then idle the bus.
    task automatic beat(input logic [7:0] p, input logic s, input logic [3:0] sh,
                        input logic f, input logic l);
        psum_in = p; s_psum = s; shift_amt = sh; in_first = f; in_last = l;
        in_valid = 1'b1;
        #1;
        chk("in_ready_before_beat", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; psum_in = 8'd0; s_psum = 1'b0; shift_amt = 4'd0;
        in_first = 1'b0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc_out",   32'(acc_out),   32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sat",       32'(sat),       32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_beat_cnt",  32'(beat_cnt),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        idle_cycle();

        // Reset in the middle of an accumulation (acc = 37).
        beat(8'd37, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("mid_beat_cnt",  32'(beat_cnt),  32'd1);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_beat_cnt",  32'(beat_cnt),  32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_acc_out",   32'(acc_out),   32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        beat(8'd5, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("post_rst_acc_out",   32'(acc_out),   32'd5);
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        idle_cycle();
        chk("post_rst_drained", 32'(out_valid), 32'd0);

        // Signed 8x8 multiply built from four 4-bit partial products.
        beat(8'h06, 1'b1, 4'd0, 1'b1, 1'b0);
        beat(8'hFE, 1'b1, 4'd4, 1'b0, 1'b0);
        beat(8'hFD, 1'b1, 4'd4, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 4'd8, 1'b0, 1'b1);
        chk("mul_acc_out",   32'(acc_out),   32'd182);
        chk("mul_sat",       32'(sat),       32'd0);
        chk("mul_beat_cnt",  32'(beat_cnt),  32'd4);
        chk("mul_out_valid", 32'(out_valid), 32'd1);
        idle_cycle();
        chk("mul_drained", 32'(out_valid), 32'd0);

        // Back-to-back single-beat sums with the consumer always ready.
        beat(8'd7, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_acc",   32'(acc_out),   32'd7);
        beat(8'hFD, 1'b1, 4'd0, 1'b1, 1'b1);
        chk("b2b_second_valid", 32'(out_valid), 32'd1);
        chk("b2b_second_acc",   32'(acc_out),   32'hFFFFFD);
        idle_cycle();
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: result held for three cycles, waiting beat not consumed.
        out_ready = 1'b0;
        beat(8'd9, 1'b0, 4'd0, 1'b1, 1'b1);
        psum_in = 8'd4; s_psum = 1'b0; shift_amt = 4'd0;
        in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("bp_acc_stable",  32'(acc_out),   32'd9);
            chk("bp_valid_held",  32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        chk("bp_consumed_acc",   32'(acc_out),   32'd4);
        chk("bp_consumed_valid", 32'(out_valid), 32'd1);
        idle_cycle();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Positive saturation: 3 x (127 << 15) exceeds 0x7FFFFF.
        beat(8'h7F, 1'b0, 4'd15, 1'b1, 1'b0);
        beat(8'h7F, 1'b0, 4'd15, 1'b0, 1'b0);
        beat(8'h7F, 1'b0, 4'd15, 1'b0, 1'b1);
        chk("satp_acc_out", 32'(acc_out), 32'h7FFFFF);
        chk("satp_sat",     32'(sat),     32'd1);
        idle_cycle();

        // Negative boundary: 2 x (-128 << 15) is exactly the minimum, no clamp.
        beat(8'h80, 1'b1, 4'd15, 1'b1, 1'b0);
        beat(8'h80, 1'b1, 4'd15, 1'b0, 1'b1);
        chk("min_exact_acc", 32'(acc_out), 32'h800000);
        chk("min_exact_sat", 32'(sat),     32'd0);
        idle_cycle();

        // One more beat goes below the minimum and clamps.
        beat(8'h80, 1'b1, 4'd15, 1'b1, 1'b0);
        beat(8'h80, 1'b1, 4'd15, 1'b0, 1'b0);
        beat(8'h80, 1'b1, 4'd15, 1'b0, 1'b1);
        chk("satn_acc_out", 32'(acc_out), 32'h800000);
        chk("satn_sat",     32'(sat),     32'd1);
        idle_cycle();

        // Restart mid-accumulation: in_first discards the partial sum.
        beat(8'd10, 1'b0, 4'd0, 1'b1, 1'b0);
        beat(8'd20, 1'b0, 4'd0, 1'b1, 1'b0);
        beat(8'd1,  1'b0, 4'd0, 1'b0, 1'b1);
        chk("restart_acc",      32'(acc_out),  32'd21);
        chk("restart_beat_cnt", 32'(beat_cnt), 32'd2);
        chk("restart_sat",      32'(sat),      32'd0);
        idle_cycle();

        // Beat in IDLE without in_first still opens a new sum.
        beat(8'd3, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("implicit_first_acc", 32'(acc_out), 32'd3);
        idle_cycle();

        // Overrun: 65 beats without in_last.
        beat(8'd1, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 63; i++) begin
            beat(8'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        chk("ovr_cnt_at_limit", 32'(beat_cnt), 32'd64);
        chk("ovr_not_yet",      32'(overrun),  32'd0);
        beat(8'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("ovr_flag",      32'(overrun),  32'd1);
        chk("ovr_cnt_sat",   32'(beat_cnt), 32'd64);
        beat(8'd2, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("ovr_restart_acc",   32'(acc_out),   32'd2);
        chk("ovr_restart_valid", 32'(out_valid), 32'd1);
        chk("ovr_sticky",        32'(overrun),   32'd1);
        chk("ovr_restart_cnt",   32'(beat_cnt),  32'd1);
        idle_cycle();
        chk("ovr_still_sticky", 32'(overrun), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fusion_psum_accumulator.md
Name: fusion_psum_accumulator

Overview:
Downstream consumer of the fusion unit's registered 8-bit partial sum (psum_fwd). It sign- or zero-extends each psum beat, left-shifts it by a per-beat shift amount, and accumulates the beats into a wide register. This composes temporally split multiplies (operands wider than 4 bits) and dot-product reductions. Each finished sum is delivered to the output buffer / next PE through a valid/ready handshake.

Parameters:
PSUM_W, 8, width of incoming psum (matches psum_fwd)
ACC_W, 24, accumulator and output width
SHIFT_W, 4, width of per-beat shift amount (0..15)
MAX_BEATS, 64, beats allowed per accumulation before overrun is flagged

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
psum_in  in  PSUM_W  partial sum from fusion unit
s_psum  in  1  1 = psum_in is two's-complement signed, 0 = unsigned
shift_amt  in  SHIFT_W  left shift applied to extended psum before accumulation
in_first  in  1  beat starts a new accumulation
in_last  in  1  beat closes the accumulation
in_valid  in  1  beat present
in_ready  out  1  accumulator can accept a beat (combinational)
acc_out  out  ACC_W  finished sum, signed
out_valid  out  1  acc_out holds a finished sum
out_ready  in  1  consumer takes acc_out
sat  out  1  finished sum was clamped (qualified by out_valid)
overrun  out  1  sticky: MAX_BEATS exceeded without in_last; cleared only by rst
beat_cnt  out  7  beats accepted in current accumulation

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, acc_out=0, out_valid=0, sat=0, overrun=0, beat_cnt=0.
- Accept condition: accept = in_valid & in_ready.
- in_ready = (state != HOLD) | out_ready. This gives zero-bubble back-to-back operation when the consumer is ready.
- Term per beat: term = ext(psum_in) << shift_amt, computed at ACC_W+1 bits.
  - ext sign-extends when s_psum=1, zero-extends otherwise.
  - Bits shifted beyond ACC_W+1 are discarded.
- Sum: next = (start ? 0 : acc) + term, computed at ACC_W+1 bits.
  - start = in_first, or state in {IDLE, HOLD}.
  - A beat arriving in IDLE/HOLD without in_first is still treated as first.
- Saturation:
  - If next > 2^(ACC_W-1)-1, clamp to the max positive value.
  - If next < -2^(ACC_W-1), clamp to the min negative value.
  - A clamp sets the internal sat_acc flag. sat_acc resets on start and is otherwise OR-accumulated.
- FSM:
  - IDLE: accept & ~in_last -> ACCUM (acc<=next, beat_cnt<=1). accept & in_last -> HOLD.
  - ACCUM: accept & ~in_last -> ACCUM (acc<=next, beat_cnt+1). accept & in_last -> HOLD.
  - ACCUM with accept & in_first: restart. Partial sum is discarded, acc<=term, beat_cnt<=1.
  - HOLD: out_valid=1. out_ready & ~accept -> IDLE. out_ready & accept -> ACCUM, or stays HOLD if in_last. ~out_ready -> stay HOLD, in_ready=0, acc_out stable.
- Entering HOLD: acc_out<=next (clamped), sat<=sat_acc|clamp_now, out_valid<=1 on the same edge. Latency is 1 cycle from the last accepted beat to out_valid.
- out_valid deasserts the cycle after the handshake unless a new sum completes on that same edge.
- acc_out and sat hold their last values while out_valid=0.
- Overrun: when beat_cnt==MAX_BEATS and a further non-first, non-last beat is accepted:
  - overrun<=1.
  - beat_cnt saturates at MAX_BEATS.
  - Accumulation continues.
- Simultaneous in_first & in_last: single-beat sum; goes straight to HOLD with acc_out=term.
- Reset mid-operation: all state is cleared immediately and any pending output is dropped. Inputs are ignored until rst deasserts.

Test Plan:
- Reset during ACCUM with acc=37 and out_valid=0 -> all outputs 0 asynchronously; next beat psum=5, first&last -> acc_out=5 one cycle later.
- Signed 8b×8b composition: four beats from 4-bit fusion, s_psum=1. Beats: psum=0x06 shift 0; 0xFE shift 4; 0xFD shift 4; 0x01 shift 8 (last) -> acc_out = 6 - 32 - 48 + 256 = 182, sat=0, beat_cnt=4.
- Back-to-back with out_ready=1: two single-beat sums (7, then -3 with s_psum=1) on consecutive cycles -> out_valid high two consecutive cycles, acc_out 7 then 0xFFFFFD, in_ready never low.
- Backpressure: sum completes with out_ready=0 for 3 cycles -> in_ready=0, acc_out stable, new in_valid beat not consumed; consumed on the cycle out_ready rises.
- Saturation with ACC_W=24: repeated psum=0x7F, shift 15, unsigned, until positive overflow -> acc_out=0x7FFFFF, sat=1 with out_valid.
- Overrun and restart: 65 beats without last -> overrun=1 sticky, beat_cnt=64. Then an in_first beat psum=2 with in_last -> acc_out=2, overrun still 1.
